// File: rtl/event_lut_pkg.sv
// Shared types and index helper for the programmable 3-D event lookup engine.
package event_lut_pkg;

  // Index fields inside lut_req_t are carried at this width; IDX_W must not exceed it.
  localparam int unsigned LUT_IDX_MAX_W = 8;

  typedef enum logic {
    MODE_DEFAULT   = 1'b0,
    MODE_LASTPLANE = 1'b1
  } lut_mode_e;

  typedef struct packed {
    logic [LUT_IDX_MAX_W-1:0] a;
    logic [LUT_IDX_MAX_W-1:0] b;
    logic [LUT_IDX_MAX_W-1:0] c;
    lut_mode_e                mode;
  } lut_req_t;

  function automatic int unsigned lut_flat_idx(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c,
                                               input int unsigned dim_b,
                                               input int unsigned dim_c);
    return a * dim_b * dim_c + b * dim_c + c;
  endfunction

endpackage

// File: rtl/event_lut_store.sv
// Register-based lookup table: range-checked single-cycle write port and
// combinational read at a flat index.
module event_lut_store
  import event_lut_pkg::*;
#(
  parameter int unsigned       DIM_A    = 3,
  parameter int unsigned       DIM_B    = 3,
  parameter int unsigned       DIM_C    = 3,
  parameter int unsigned       IDX_W    = 2,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int unsigned       DEPTH    = DIM_A * DIM_B * DIM_C,
  parameter int unsigned       FLAT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_a,
  input  logic [IDX_W-1:0]  wr_b,
  input  logic [IDX_W-1:0]  wr_c,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [FLAT_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_ok;
  logic [FLAT_W-1:0] wr_flat;

  // Out-of-range writes are dropped without any indication.
  assign wr_ok   = wr_en && (32'(wr_a) < DIM_A) && (32'(wr_b) < DIM_B) && (32'(wr_c) < DIM_C);
  assign wr_flat = FLAT_W'(lut_flat_idx(32'(wr_a), 32'(wr_b), 32'(wr_c), DIM_B, DIM_C));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= INIT_VAL;
        end else if (wr_ok && (wr_flat == FLAT_W'(gi))) begin
          mem_q[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = (32'(rd_idx) < DEPTH) ? mem_q[rd_idx] : INIT_VAL;

endmodule

// File: rtl/event_lut_engine.sv
// Two-stage valid/ready lookup pipeline over event_lut_store with out-of-range
// fallback resolution and a saturating fault counter.
module event_lut_engine
  import event_lut_pkg::*;
#(
  parameter int unsigned       DIM_A       = 3,
  parameter int unsigned       DIM_B       = 3,
  parameter int unsigned       DIM_C       = 3,
  parameter int unsigned       IDX_W       = 2,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] INIT_VAL    = '0,
  parameter logic [DATA_W-1:0] DEFAULT_VAL = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_a,
  input  logic [IDX_W-1:0]  req_b,
  input  logic [IDX_W-1:0]  req_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_a,
  input  logic [IDX_W-1:0]  wr_b,
  input  logic [IDX_W-1:0]  wr_c,
  input  logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  fault_cnt,
  input  logic              clr_cnt
);

  localparam int unsigned DEPTH  = DIM_A * DIM_B * DIM_C;
  localparam int unsigned FLAT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lut_req_t          req_s;
  lut_req_t          s1_req_q;
  logic              s1_v_q, s1_fa_q, s1_fb_q, s1_fc_q;
  logic              s2_v_q, s2_fault_q;
  logic [DATA_W-1:0] s2_data_q;
  logic [DATA_W-1:0] s2_data_d;
  logic              s2_fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              s1_adv, s2_adv, accept;
  logic              in_fa, in_fb, in_fc;
  logic              use_tbl;
  int unsigned       rd_a;
  logic [FLAT_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data;

  assign s2_adv    = !s2_v_q || rsp_ready;
  assign s1_adv    = !s1_v_q || s2_adv;
  assign req_ready = s1_adv;
  assign accept    = req_valid && s1_adv;

  assign in_fa = 32'(req_a) >= DIM_A;
  assign in_fb = 32'(req_b) >= DIM_B;
  assign in_fc = 32'(req_c) >= DIM_C;

  always_comb begin
    req_s                = '0;
    req_s.a[IDX_W-1:0]   = req_a;
    req_s.b[IDX_W-1:0]   = req_b;
    req_s.c[IDX_W-1:0]   = req_c;
    req_s.mode           = lut_mode_e'(mode);
  end

  // Only a lone plane fault in LASTPLANE mode is redirected into the table.
  always_comb begin
    s2_fault_d = s1_fa_q || s1_fb_q || s1_fc_q;
    use_tbl    = !s2_fault_d ||
                 ((s1_req_q.mode == MODE_LASTPLANE) && s1_fa_q && !s1_fb_q && !s1_fc_q);
    rd_a       = s1_fa_q ? (DIM_A - 1) : 32'(s1_req_q.a);
    rd_idx     = '0;
    if (use_tbl) begin
      rd_idx = FLAT_W'(lut_flat_idx(rd_a, 32'(s1_req_q.b), 32'(s1_req_q.c), DIM_B, DIM_C));
    end
    s2_data_d  = use_tbl ? rd_data : DEFAULT_VAL;
  end

  event_lut_store #(
    .DIM_A    (DIM_A),
    .DIM_B    (DIM_B),
    .DIM_C    (DIM_C),
    .IDX_W    (IDX_W),
    .DATA_W   (DATA_W),
    .INIT_VAL (INIT_VAL)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_a    (wr_a),
    .wr_b    (wr_b),
    .wr_c    (wr_c),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // The table is read on the S1->S2 edge, so a same-edge write is seen by the next read only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_req_q   <= '0;
      s1_fa_q    <= 1'b0;
      s1_fb_q    <= 1'b0;
      s1_fc_q    <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_data_q  <= '0;
      s2_fault_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v_q <= req_valid;
        if (req_valid) begin
          s1_req_q <= req_s;
          s1_fa_q  <= in_fa;
          s1_fb_q  <= in_fb;
          s1_fc_q  <= in_fc;
        end
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_data_q  <= s2_data_d;
          s2_fault_q <= s2_fault_d;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (accept && (in_fa || in_fb || in_fc) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign rsp_valid = s2_v_q;
  assign rsp_data  = s2_data_q;
  assign rsp_fault = s2_fault_q;
  assign fault_cnt = cnt_q;

endmodule

// File: tb/tb_event_lut_engine.sv
// Directed self-checking bench for event_lut_engine (default build plus a
// 2-bit fault counter build for saturation).
module tb_event_lut_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode, req_valid, rsp_ready, wr_en, clr_cnt;
  logic [1:0] req_a, req_b, req_c, wr_a, wr_b, wr_c;
  logic [7:0] wr_data;
  logic       req_ready, rsp_valid, rsp_fault;
  logic [7:0] rsp_data;
  logic [15:0] fault_cnt;

  logic       u2_mode, u2_req_valid, u2_rsp_ready, u2_wr_en, u2_clr_cnt;
  logic [1:0] u2_req_a, u2_req_b, u2_req_c, u2_wr_a, u2_wr_b, u2_wr_c;
  logic [7:0] u2_wr_data;
  logic       u2_req_ready, u2_rsp_valid, u2_rsp_fault;
  logic [7:0] u2_rsp_data;
  logic [1:0] u2_fault_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  event_lut_engine dut (
    .clk(clk), .rst(rst), .mode(mode),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .wr_c(wr_c), .wr_data(wr_data),
    .fault_cnt(fault_cnt), .clr_cnt(clr_cnt)
  );

  event_lut_engine #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .mode(u2_mode),
    .req_valid(u2_req_valid), .req_ready(u2_req_ready),
    .req_a(u2_req_a), .req_b(u2_req_b), .req_c(u2_req_c),
    .rsp_valid(u2_rsp_valid), .rsp_ready(u2_rsp_ready),
    .rsp_data(u2_rsp_data), .rsp_fault(u2_rsp_fault),
    .wr_en(u2_wr_en), .wr_a(u2_wr_a), .wr_b(u2_wr_b), .wr_c(u2_wr_c), .wr_data(u2_wr_data),
    .fault_cnt(u2_fault_cnt), .clr_cnt(u2_clr_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
    if (obs === exp) $display("ok   %s: 0x%0h", tag, obs);
  endtask

  task automatic write(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                       input logic [7:0] d);
    wr_en = 1'b1; wr_a = a; wr_b = b; wr_c = c; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
    req_valid = 1'b1; req_a = a; req_b = b; req_c = c;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; wr_en = 1'b0; clr_cnt = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; wr_a = '0; wr_b = '0; wr_c = '0; wr_data = '0;
    u2_mode = 1'b0; u2_req_valid = 1'b0; u2_rsp_ready = 1'b1; u2_wr_en = 1'b0; u2_clr_cnt = 1'b0;
    u2_req_a = '0; u2_req_b = '0; u2_req_c = '0; u2_wr_a = '0; u2_wr_b = '0; u2_wr_c = '0;
    u2_wr_data = '0;
    tick(); tick();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_fault_cnt", 32'(fault_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd1);

    // 1: unwritten entry reads INIT_VAL with 2-cycle latency
    drive(2'd1, 2'd2, 2'd0);
    tick();
    req_valid = 1'b0;
    check("t1_valid_early", 32'(rsp_valid), 32'd0);
    tick();
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_data",  32'(rsp_data),  32'h00);
    check("t1_fault", 32'(rsp_fault), 32'd0);
    check("t1_cnt",   32'(fault_cnt), 32'd0);
    tick();

    // 2: write then read on the next cycle
    write(2'd2, 2'd1, 2'd2, 8'hA5);
    drive(2'd2, 2'd1, 2'd2);
    tick();
    req_valid = 1'b0;
    check("t2_valid_early", 32'(rsp_valid), 32'd0);
    tick();
    check("t2_valid", 32'(rsp_valid), 32'd1);
    check("t2_data",  32'(rsp_data),  32'hA5);
    tick();

    // 3: back-pressure with three queued reads
    write(2'd0, 2'd0, 2'd0, 8'h10);
    write(2'd1, 2'd1, 2'd1, 8'h21);
    write(2'd2, 2'd2, 2'd2, 8'h32);
    rsp_ready = 1'b0;
    drive(2'd0, 2'd0, 2'd0);
    check("t3_ready0", 32'(req_ready), 32'd1);
    tick();
    drive(2'd1, 2'd1, 2'd1);
    check("t3_ready1", 32'(req_ready), 32'd1);
    tick();
    drive(2'd2, 2'd2, 2'd2);
    check("t3_ready_drop", 32'(req_ready), 32'd0);
    check("t3_hold_valid", 32'(rsp_valid), 32'd1);
    check("t3_hold_data0", 32'(rsp_data),  32'h10);
    tick();
    check("t3_hold_data1", 32'(rsp_data),  32'h10);
    tick();
    check("t3_hold_data2", 32'(rsp_data),  32'h10);
    check("t3_ready_held", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    check("t3_rsp1_valid", 32'(rsp_valid), 32'd1);
    check("t3_rsp1_data",  32'(rsp_data),  32'h21);
    tick();
    check("t3_rsp2_valid", 32'(rsp_valid), 32'd1);
    check("t3_rsp2_data",  32'(rsp_data),  32'h32);
    tick();
    check("t3_drained", 32'(rsp_valid), 32'd0);

    // 4: LASTPLANE redirect, then DEFAULT fallback
    write(2'd2, 2'd0, 2'd1, 8'h3C);
    mode = 1'b1;
    drive(2'd3, 2'd0, 2'd1);
    tick();
    req_valid = 1'b0;
    check("t4_cnt1", 32'(fault_cnt), 32'd1);
    tick();
    check("t4_lp_data",  32'(rsp_data),  32'h3C);
    check("t4_lp_fault", 32'(rsp_fault), 32'd1);
    mode = 1'b0;
    drive(2'd0, 2'd3, 2'd0);
    tick();
    req_valid = 1'b0;
    check("t4_cnt2", 32'(fault_cnt), 32'd2);
    tick();
    check("t4_def_valid", 32'(rsp_valid), 32'd1);
    check("t4_def_data",  32'(rsp_data),  32'h00);
    check("t4_def_fault", 32'(rsp_fault), 32'd1);
    tick();

    // 5: read-before-write on the S1->S2 edge
    write(2'd1, 2'd0, 2'd0, 8'h11);
    drive(2'd1, 2'd0, 2'd0);
    tick();
    req_valid = 1'b0;
    wr_en = 1'b1; wr_a = 2'd1; wr_b = 2'd0; wr_c = 2'd0; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    check("t5_old_valid", 32'(rsp_valid), 32'd1);
    check("t5_old_data",  32'(rsp_data),  32'h11);
    drive(2'd1, 2'd0, 2'd0);
    tick();
    req_valid = 1'b0;
    tick();
    check("t5_new_data", 32'(rsp_data), 32'h77);
    tick();

    // 6: reset with two requests in flight
    drive(2'd0, 2'd0, 2'd0);
    tick();
    drive(2'd1, 2'd1, 2'd1);
    tick();
    req_valid = 1'b0;
    check("t6_inflight", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(rsp_valid), 32'd0);
    check("t6_rst_cnt",   32'(fault_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_no_stale0", 32'(rsp_valid), 32'd0);
    tick();
    check("t6_no_stale1", 32'(rsp_valid), 32'd0);
    drive(2'd2, 2'd1, 2'd2);
    tick();
    req_valid = 1'b0;
    tick();
    check("t6_table_cleared", 32'(rsp_data), 32'h00);
    tick();

    // 6b: 2-bit counter saturates, clear beats simultaneous fault
    for (int i = 0; i < 5; i++) begin
      u2_req_valid = 1'b1; u2_req_a = 2'd3; u2_req_b = 2'd0; u2_req_c = 2'd0;
      tick();
      check($sformatf("t6_sat_cnt%0d", i), 32'(u2_fault_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    u2_clr_cnt = 1'b1;
    tick();
    u2_clr_cnt = 1'b0;
    u2_req_valid = 1'b0;
    check("t6_clr_wins", 32'(u2_fault_cnt), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
